ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
- Multi-cycle controller and iterative datapath for RV32M DIV/DIVU/REM/REMU.
- Sits beside the EX-stage ALU. EX issues a start request; the block holds the pipeline via stallreq_o while it iterates, then returns the result to EX's write-back mux for one cycle.
- Handles the divide-by-zero and signed-overflow special cases in a single cycle.
- Aborts on pipeline flush.

Parameters:
- DATA_W, 32, operand and result width (RegBus)
- ADDR_W, 5, destination register address width (RegAddrBus)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  EX requests a division this cycle
- annul_i  input  1  flush; cancels a pending or running division
- signed_i  input  1  1 = DIV/REM, 0 = DIVU/REMU
- rem_i  input  1  1 = return remainder, 0 = return quotient
- dividend_i  input  DATA_W  rs1 value
- divisor_i  input  DATA_W  rs2 value
- wd_i  input  ADDR_W  destination register
- result_o  output  DATA_W  quotient or remainder; valid while ready_o is high
- ready_o  output  1  result valid, high for exactly one cycle
- wd_o  output  ADDR_W  destination register latched at start
- busy_o  output  1  state is not IDLE
- stallreq_o  output  1  stall request to the pipeline controller

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - result_o, wd_o, ready_o, busy_o and the internal counter are all cleared to 0.
  - Reset mid-operation discards all work.
- States: IDLE, ON, END.
- IDLE, start_i=1 and annul_i=0 at an edge (call it E0):
  - Latch signed_i, rem_i and wd_i.
  - For signed operations, latch absolute values of both operands and record the quotient sign (sign of dividend XOR sign of divisor) and the remainder sign (sign of dividend).
  - If divisor = 0: result is 0xFFFFFFFF (quotient) or the dividend (remainder); go to END.
  - Else if signed and dividend = 0x80000000 and divisor = 0xFFFFFFFF: result is 0x80000000 (quotient) or 0 (remainder); go to END.
  - Otherwise go to ON with the counter = 0.
- ON:
  - One restoring step per edge: shift {rem, quo} left by 1; trial-subtract the divisor; if there is no borrow, keep the difference and set the quotient LSB to 1.
  - The counter increments each edge. After the 32nd step, at edge E32, go to END.
  - On entering END, apply the sign correction (two's complement of the magnitude where the recorded sign is negative) and select the quotient or remainder into result_o.
- END:
  - ready_o = 1 for this one cycle; the next edge returns to IDLE and clears ready_o.
  - result_o holds its value until the next completion.
- Latency:
  - Normal case: ready_o is high in the cycle following E32, i.e. 33 cycles after the start cycle.
  - Special cases: ready_o is high in the cycle following E0.
- stallreq_o (combinational) = (IDLE and start_i and not annul_i) or ON. It is low in END so that EX captures the result.
- annul_i:
  - In IDLE it suppresses the start.
  - In ON or END the next edge forces IDLE, ready_o stays or becomes 0, and no result is produced.
  - annul_i has priority over completion when both occur at the same edge.
- start_i while not in IDLE is ignored; busy_o = 1.
- Back-to-back: a start in the cycle after END (state IDLE) is accepted normally.
- All arithmetic is DATA_W+1 bits wide for the trial subtract. The counter is 6 bits and saturates logic is not needed because the state exits at 32.

Decomposition:
- defines.vh:
  - state encodings: DivIdle, DivOn, DivEnd
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - the 0x80000000 and all-ones constants
  - RegBus and RegAddrBus widths, already present
- Sub-module: div_step, a combinational single iteration taking rem, quo and divisor and returning the next rem and quo. It is instantiated once inside the ex_div_ctrl FSM.

Test Plan:
- DIVU 100/7, start at cycle 0:
  - stallreq_o is high for cycles 0..32.
  - ready_o is high only in cycle 33 with result_o = 14; wd_o equals the latched wd_i.
  - The same operands with rem_i=1 give 2.
- DIV -7/2 gives result_o = 0xFFFFFFFD. REM -7/2 gives 0xFFFFFFFF. REM 7/-2 gives 1.
- DIVU 5/0 gives 0xFFFFFFFF with ready_o in cycle 1. REMU 5/0 gives 5.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000 with ready_o in cycle 1. REM of the same operands gives 0.
- annul_i pulsed at iteration 10: state returns to IDLE the next cycle and ready_o never asserts. A new start of 9/3 one cycle later gives 3 after 33 cycles.
- rst driven low during iteration 20: all outputs are 0 immediately, with no clock edge required. After release, a 0xFFFFFFFF/1 DIVU returns 0xFFFFFFFF. start_i pulses while busy have no effect.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// rtl/ex_div_ctrl_pkg.sv - shared state encoding and constants for the RV32M divider
package ex_div_ctrl_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ADDR_W = 5;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_END  = 2'd2
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Counter value seen on the edge that performs the final restoring step.
  localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = 6'd31;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// rtl/ex_div_ctrl_div_step.sv - one combinational restoring-division iteration
module ex_div_ctrl_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  // rem < dvs always holds, so diff[DATA_W] is exactly the borrow of the trial subtract.
  always_comb begin
    rem_sh = {rem_i, quo_i[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_i};
    if (!diff[DATA_W]) begin
      rem_o = diff[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - multi-cycle DIV/DIVU/REM/REMU controller beside the EX-stage ALU
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int ADDR_W = DIV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_i,
  input  logic              rem_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [ADDR_W-1:0] wd_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              busy_o,
  output logic              stallreq_o
);

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 rem_sel_q, rem_sel_d;
  logic [ADDR_W-1:0]    wd_q, wd_d;
  logic [DATA_W-1:0]    result_q, result_d;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;
  logic              dvd_neg;
  logic              dvs_neg;
  logic [DATA_W-1:0] dvd_abs;
  logic [DATA_W-1:0] dvs_abs;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              accept;

  ex_div_ctrl_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    dvd_neg = signed_i & dividend_i[DATA_W-1];
    dvs_neg = signed_i & divisor_i[DATA_W-1];
    dvd_abs = dvd_neg ? (ZERO - dividend_i) : dividend_i;
    dvs_abs = dvs_neg ? (ZERO - divisor_i) : divisor_i;
    quo_fix = neg_quo_q ? (ZERO - step_quo) : step_quo;
    rem_fix = neg_rem_q ? (ZERO - step_rem) : step_rem;
    accept  = (state_q == DIV_IDLE) && start_i && !annul_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    wd_d      = wd_q;
    result_d  = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          rem_sel_d = rem_i;
          wd_d      = wd_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          rem_d     = ZERO;
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          cnt_d     = '0;
          // Both special cases complete without iterating.
          if (divisor_i == ZERO) begin
            result_d = rem_i ? dividend_i : ALL_ONES;
            state_d  = DIV_END;
          end else if (signed_i && dividend_i == MIN_NEG && divisor_i == ALL_ONES) begin
            result_d = rem_i ? ZERO : MIN_NEG;
            state_d  = DIV_END;
          end else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == DIV_LAST_STEP) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      wd_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      wd_q      <= wd_d;
      result_q  <= result_d;
    end
  end

  // Stall is dropped in END so EX latches the result on that cycle.
  always_comb begin
    result_o   = result_q;
    wd_o       = wd_q;
    busy_o     = (state_q != DIV_IDLE);
    ready_o    = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    stallreq_o = (accept || state_q == DIV_ON) ? DIV_START : DIV_STOP;
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - self-checking bench for ex_div_ctrl
module tb_ex_div_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic          signed_i;
  logic          rem_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic [AW-1:0] wd_i;
  logic [DW-1:0] result_o;
  logic          ready_o;
  logic [AW-1:0] wd_o;
  logic          busy_o;
  logic          stallreq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_div_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .rem_i      (rem_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .wd_i       (wd_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .wd_o       (wd_o),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] model(input bit s, input bit r,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (!s) return r ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return r ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves END.
  task automatic do_div(input string tag, input bit s, input bit r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input bit noise);
    logic [31:0] exp;
    int exp_lat;
    int cyc;
    bit seen;
    int stall_bad;
    exp     = model(s, r, a, b);
    exp_lat = (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    signed_i = s; rem_i = r; dividend_i = a; divisor_i = b; wd_i = wd; start_i = 1'b1;
    @(negedge clk);
    stall_bad = (stallreq_o !== 1'b1) ? 1 : 0;
    @(posedge clk);
    #1 start_i = 1'b0;
    seen = 1'b0;
    cyc  = 1;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_wd"}, 32'(wd_o), 32'(wd));
        chk({tag, "_stall_end"}, 32'(stallreq_o), 32'd0);
      end else begin
        if (stallreq_o !== 1'b1 || busy_o !== 1'b1) stall_bad++;
        if (noise) begin
          start_i    = (cyc >= 4 && cyc < 20 && cyc[0]);
          dividend_i = $urandom;
          divisor_i  = $urandom;
          signed_i   = 1'($urandom);
          rem_i      = 1'($urandom);
          wd_i       = 5'($urandom);
        end
        cyc++;
      end
    end
    start_i = 1'b0;
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_stall"}, 32'(stall_bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit s, r;
    int kind;

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    dividend_i = '0; divisor_i = '0; wd_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result_o, 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_div("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 5'd3, 1'b0);
    do_div("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 5'd4, 1'b0);
    do_div("div_m7_2",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
    do_div("rem_m7_2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    do_div("rem_7_m2",   1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd7, 1'b0);
    do_div("divu_5_0",   1'b0, 1'b0, 32'd5, 32'd0, 5'd8, 1'b0);
    do_div("remu_5_0",   1'b0, 1'b1, 32'd5, 32'd0, 5'd9, 1'b0);
    do_div("div_ovf",    1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_div("rem_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);

    // A start that coincides with a flush must not be taken.
    signed_i = 1'b0; rem_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5; wd_i = 5'd12;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    chk("annul_idle_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    chk("annul_idle_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Flush partway through the iterations.
    dividend_i = 32'd1000; divisor_i = 32'd3; wd_i = 5'd13; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    chk("annul_on_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 annul_i = 1'b0;
    @(negedge clk);
    chk("annul_after_busy", 32'(busy_o), 32'd0);
    chk("annul_after_ready", 32'(ready_o), 32'd0);
    chk("annul_after_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1;
    do_div("div_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 5'd14, 1'b0);

    // Asynchronous reset in the middle of iterating.
    dividend_i = 32'h0001_2345; divisor_i = 32'd7; wd_i = 5'd15; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_result", result_o, 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_wd", 32'(wd_o), 32'd0);
    chk("arst_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_div("divu_max_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd16, 1'b1);

    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 7);
      s = 1'($urandom);
      r = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (kind == 0) b = 32'd0;
      if (kind == 1) begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (kind == 2) b = 32'($urandom_range(1, 20));
      if (kind == 3) b = b >> $urandom_range(1, 31);
      do_div($sformatf("rnd%0d", i), s, r, a, b, 5'($urandom), bit'(i % 3 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
